// File: rtl/mdu_param.sv
// Multiply/divide unit with HI/LO registers: configurable width and per-class latency,
// MADD/MSUB accumulation, defined divide-by-zero/overflow results and cancel on flush.
module mdu_param #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e             state_r, state_nxt_s;
  logic [CW-1:0]      cnt_r;
  logic               busy_r, res_we_r;
  logic [WIDTH-1:0]   hi_r, lo_r, res_hi_r, res_lo_r;
  logic               is_mul_s, is_div_s, launch_s, done_s, mt_ok_s, res_we_s;
  logic [2*WIDTH-1:0] sprod_s, uprod_s, acc_s, res_s;
  logic [WIDTH-1:0]   dvs_s, uq_s, ur_s, sa_s, sb_s, sq_mag_s, sr_mag_s, sq_s, sr_s;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    neg = ZERO - v;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    mag = v[WIDTH-1] ? neg(v) : v;
  endfunction

  // Result is computed at launch from the operands and current HI/LO, then held.
  always_comb begin
    sprod_s  = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    uprod_s  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    acc_s    = {hi_r, lo_r};
    dvs_s    = (b == ZERO) ? ONE : b;
    uq_s     = a / dvs_s;
    ur_s     = a % dvs_s;
    sa_s     = mag(a);
    sb_s     = (b == ZERO) ? ONE : mag(b);
    sq_mag_s = sa_s / sb_s;
    sr_mag_s = sa_s % sb_s;
    // MIN / -1 falls out naturally: quotient magnitude 2^(W-1) negates back to MIN.
    sq_s     = (a[WIDTH-1] ^ b[WIDTH-1]) ? neg(sq_mag_s) : sq_mag_s;
    sr_s     = a[WIDTH-1] ? neg(sr_mag_s) : sr_mag_s;
    res_s    = acc_s;
    res_we_s = 1'b1;
    case (op)
      OP_MULT:  res_s = sprod_s;
      OP_MULTU: res_s = uprod_s;
      OP_DIV: begin
        res_s    = {sr_s, sq_s};
        res_we_s = (b != ZERO);
      end
      OP_DIVU: begin
        res_s    = {ur_s, uq_s};
        res_we_s = (b != ZERO);
      end
      OP_MADD:  res_s = acc_s + sprod_s;
      OP_MADDU: res_s = acc_s + uprod_s;
      OP_MSUB:  res_s = acc_s - sprod_s;
      OP_MSUBU: res_s = acc_s - uprod_s;
      default: begin
        res_s    = acc_s;
        res_we_s = 1'b0;
      end
    endcase
  end

  // Op class decode and IDLE/RUN next-state logic.
  always_comb begin
    is_mul_s    = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
                  (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    is_div_s    = (op == OP_DIV) || (op == OP_DIVU);
    mt_ok_s     = (state_r == IDLE) && !cancel;
    state_nxt_s = state_r;
    launch_s    = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !cancel && (is_mul_s || is_div_s)) begin
          state_nxt_s = RUN;
          launch_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cancel) begin
          state_nxt_s = IDLE;
        end else if (cnt_r == CW'(1)) begin
          state_nxt_s = IDLE;
          done_s      = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Counter, held result, busy flag and the architectural HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b0;
      res_we_r <= 1'b0;
      res_hi_r <= ZERO;
      res_lo_r <= ZERO;
      hi_r     <= ZERO;
      lo_r     <= ZERO;
    end else begin
      busy_r <= (state_nxt_s == RUN);
      if (launch_s) begin
        cnt_r    <= is_div_s ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
        res_hi_r <= res_s[2*WIDTH-1:WIDTH];
        res_lo_r <= res_s[WIDTH-1:0];
        res_we_r <= res_we_s;
      end else if (state_r == RUN) begin
        cnt_r <= cnt_r - CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (done_s && res_we_r)            hi_r <= res_hi_r;
      else if (mt_ok_s && op == OP_MTHI) hi_r <= a;
      else                               hi_r <= hi_r;
      if (done_s && res_we_r)            lo_r <= res_lo_r;
      else if (mt_ok_s && op == OP_MTLO) lo_r <= a;
      else                               lo_r <= lo_r;
    end
  end

  // Move-from read port follows op combinationally.
  always_comb begin
    case (op)
      OP_MFHI: rd = hi_r;
      OP_MFLO: rd = lo_r;
      default: rd = ZERO;
    endcase
  end

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mdu_param.sv
// Directed self-checking bench for mdu_param (WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10).
module tb_mdu_param;
  localparam int W = 32;

  logic         clk = 1'b0, reset = 1'b0, start = 1'b0, cancel = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy;
  logic [W-1:0] hi, lo, rd;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mdu_param #(.WIDTH(W), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo), .rd(rd)
  );

  task automatic launch(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0; a = '0; b = '0;
  endtask

  task automatic write_reg(input logic [3:0] o, input logic [W-1:0] x, input logic c);
    op = o; a = x; cancel = c;
    @(posedge clk); #1;
    op = 4'd0; a = '0; cancel = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
    end
  endtask

  task automatic test_reset();
    op = 4'd5;
    #3;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin failures++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi, lo); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_rd got=%h exp=0", rd); end
    @(posedge clk); #1;
    reset = 1'b1; op = 4'd0;
  endtask

  task automatic test_mult();
    int cyc;
    launch(4'd1, 32'hFFFFFFFD, 32'd7);
    wait_done(cyc);
    checks++; if (cyc !== 5) begin failures++; $display("FAIL mult_busy got=%0d exp=5", cyc); end
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin failures++; $display("FAIL mult_res got=%h/%h exp=ffffffff/ffffffeb", hi, lo); end
  endtask

  task automatic test_div();
    int cyc;
    launch(4'd4, 32'd100, 32'd7);
    wait_done(cyc);
    checks++; if (cyc !== 10) begin failures++; $display("FAIL divu_busy got=%0d exp=10", cyc); end
    checks++; if (hi !== 32'd2 || lo !== 32'd14) begin failures++; $display("FAIL divu_res got=%h/%h exp=2/e", hi, lo); end
    launch(4'd3, 32'hFFFFFFF9, 32'd2);
    wait_done(cyc);
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_res got=%h/%h exp=ffffffff/fffffffd", hi, lo); end
  endtask

  task automatic test_madd();
    int cyc;
    write_reg(4'd7, 32'h11, 1'b0);
    checks++; if (hi !== 32'h11 || busy !== 1'b0) begin failures++; $display("FAIL mthi got=%h busy=%b exp=11 busy=0", hi, busy); end
    write_reg(4'd8, 32'h22, 1'b0);
    checks++; if (lo !== 32'h22) begin failures++; $display("FAIL mtlo got=%h exp=22", lo); end
    launch(4'd10, 32'hFFFFFFFF, 32'd2);
    wait_done(cyc);
    checks++; if (cyc !== 5) begin failures++; $display("FAIL maddu_busy got=%0d exp=5", cyc); end
    checks++; if (hi !== 32'h13 || lo !== 32'h20) begin failures++; $display("FAIL maddu_res got=%h/%h exp=13/20", hi, lo); end
    op = 4'd5; #1;
    checks++; if (rd !== 32'h13) begin failures++; $display("FAIL rd_mfhi got=%h exp=13", rd); end
    op = 4'd6; #1;
    checks++; if (rd !== 32'h20) begin failures++; $display("FAIL rd_mflo got=%h exp=20", rd); end
    op = 4'd0; #1;
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rd_none got=%h exp=0", rd); end
    launch(4'd11, 32'd2, 32'd3);
    wait_done(cyc);
    checks++; if (hi !== 32'h13 || lo !== 32'h1A) begin failures++; $display("FAIL msub_res got=%h/%h exp=13/1a", hi, lo); end
  endtask

  task automatic test_div_edge();
    int cyc;
    launch(4'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_done(cyc);
    checks++; if (hi !== 32'h0 || lo !== 32'h80000000) begin failures++; $display("FAIL div_ovf got=%h/%h exp=0/80000000", hi, lo); end
    write_reg(4'd7, 32'hAA, 1'b0);
    write_reg(4'd8, 32'h55, 1'b0);
    launch(4'd3, 32'd9, 32'd0);
    wait_done(cyc);
    checks++; if (cyc !== 10) begin failures++; $display("FAIL div0_busy got=%0d exp=10", cyc); end
    checks++; if (hi !== 32'hAA || lo !== 32'h55) begin failures++; $display("FAIL div0_res got=%h/%h exp=aa/55", hi, lo); end
  endtask

  task automatic test_cancel();
    launch(4'd1, 32'd6, 32'd7);
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL cancel_pre_busy got=%b exp=1", busy); end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cancel_busy got=%b exp=0", busy); end
    repeat (8) @(negedge clk);
    checks++; if (hi !== 32'hAA || lo !== 32'h55) begin failures++; $display("FAIL cancel_hilo got=%h/%h exp=aa/55", hi, lo); end
    cancel = 1'b1;
    launch(4'd1, 32'd6, 32'd7);
    cancel = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_cancel_busy got=%b exp=0", busy); end
    write_reg(4'd7, 32'h99, 1'b1);
    checks++; if (hi !== 32'hAA) begin failures++; $display("FAIL mthi_cancel got=%h exp=aa", hi); end
  endtask

  task automatic test_async_reset();
    launch(4'd4, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin failures++; $display("FAIL async_reset got busy=%b hi=%h lo=%h exp=0/0/0", busy, hi, lo); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    int cyc;
    launch(4'd1, 32'd2, 32'd3);
    wait_done(cyc);
    checks++; if (hi !== 32'h0 || lo !== 32'h6) begin failures++; $display("FAIL b2b_mult got=%h/%h exp=0/6", hi, lo); end
    launch(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(cyc);
    checks++; if (cyc !== 5) begin failures++; $display("FAIL b2b_busy got=%0d exp=5", cyc); end
    checks++; if (hi !== 32'hFFFFFFFE || lo !== 32'h1) begin failures++; $display("FAIL b2b_multu got=%h/%h exp=fffffffe/1", hi, lo); end
    launch(4'd9, 32'hFFFFFFFF, 32'd1);
    wait_done(cyc);
    checks++; if (hi !== 32'hFFFFFFFE || lo !== 32'h0) begin failures++; $display("FAIL b2b_madd got=%h/%h exp=fffffffe/0", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_madd();
    test_div_edge();
    test_cancel();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
